// File: rtl/agc_loop_master.sv
// AGC loop master: Wishbone initiator that runs tick/poll/read/calc/write/apply
// iterations against the AGC register block without software involvement.
module agc_loop_master #(
  parameter logic [21:0]        BASE_ADDR   = 22'h0,
  parameter logic [16:0]        INIT_SCALE  = 17'h01000,
  parameter logic signed [7:0]  INIT_OFFSET = 8'sd0,
  parameter int                 KP_SHIFT    = 8,
  parameter int                 KO_SHIFT    = 10,
  parameter int                 POLL_GAP    = 16,
  parameter int                 POLL_LIMIT  = 16384,
  parameter int                 ACK_TIMEOUT = 64
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               start_i,
  input  logic               enable_i,
  input  logic [23:0]        target_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [16:0]        scale_o,
  output logic signed [7:0]  offset_o,
  output logic [23:0]        sq_o,
  output logic [20:0]        gt_o,
  output logic [20:0]        lt_o,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [21:0]        wb_adr_o,
  output logic [31:0]        wb_dat_o,
  output logic [3:0]         wb_sel_o,
  input  logic               wb_ack_i,
  input  logic [31:0]        wb_dat_i
);

  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int PW = $clog2(POLL_LIMIT + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_TICK, S_GAP, S_POLL,
    S_RD_SQ, S_RD_GT, S_RD_LT, S_CALC,
    S_WR_SCALE, S_WR_OFF, S_APPLY, S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic               stb_q, stb_d;
  logic               err_q, err_d;
  logic [AW-1:0]      ack_cnt_q, ack_cnt_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [PW-1:0]      poll_cnt_q, poll_cnt_d;
  logic [16:0]        scale_q, scale_d;
  logic signed [7:0]  offset_q, offset_d;
  logic [23:0]        sq_q, sq_d;
  logic [20:0]        gt_q, gt_d;
  logic [20:0]        lt_q, lt_d;

  logic               is_bus;
  logic               ack_ok;
  logic signed [24:0] e_w, e_sh;
  logic signed [25:0] s_w;
  logic signed [21:0] d_w, d_sh;
  logic signed [22:0] o_w;
  logic [16:0]        s_sat;
  logic signed [7:0]  o_sat;
  logic               unused_dat;

  assign unused_dat = ^wb_dat_i[31:24];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      ack_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      poll_cnt_q <= '0;
      scale_q    <= INIT_SCALE;
      offset_q   <= INIT_OFFSET;
      sq_q       <= '0;
      gt_q       <= '0;
      lt_q       <= '0;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
      ack_cnt_q  <= ack_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      scale_q    <= scale_d;
      offset_q   <= offset_d;
      sq_q       <= sq_d;
      gt_q       <= gt_d;
      lt_q       <= lt_d;
    end
  end

  // Loop arithmetic: widened so shifts and sums are exact before clamping
  always_comb begin
    e_w  = $signed({1'b0, target_i}) - $signed({1'b0, sq_q});
    e_sh = e_w >>> KP_SHIFT;
    s_w  = $signed({9'b0, scale_q}) + $signed({e_sh[24], e_sh});
    if (s_w[25])
      s_sat = 17'h0;
    else if (s_w[24:17] != 8'h0)
      s_sat = 17'h1FFFF;
    else
      s_sat = s_w[16:0];
    d_w  = $signed({1'b0, gt_q}) - $signed({1'b0, lt_q});
    d_sh = d_w >>> KO_SHIFT;
    o_w  = $signed({{15{offset_q[7]}}, offset_q})
         - $signed({d_sh[21], d_sh});
    if (o_w < -23'sd128)
      o_sat = -8'sd128;
    else if (o_w > 23'sd127)
      o_sat = 8'sd127;
    else
      o_sat = o_w[7:0];
  end

  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    err_d      = err_q;
    ack_cnt_d  = ack_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    poll_cnt_d = poll_cnt_q;
    scale_d    = scale_q;
    offset_d   = offset_q;
    sq_d       = sq_q;
    gt_d       = gt_q;
    lt_d       = lt_q;
    is_bus     = 1'b0;
    unique case (state_q)
      S_TICK, S_POLL, S_RD_SQ, S_RD_GT, S_RD_LT,
      S_WR_SCALE, S_WR_OFF, S_APPLY: is_bus = 1'b1;
      default: is_bus = 1'b0;
    endcase
    ack_ok = stb_q && wb_ack_i;
    // First cycle of each bus state is the mandatory idle gap
    if (is_bus) begin
      if (!stb_q) begin
        stb_d     = 1'b1;
        ack_cnt_d = '0;
      end else if (wb_ack_i) begin
        stb_d = 1'b0;
      end else if (ack_cnt_q == AW'(ACK_TIMEOUT - 1)) begin
        stb_d   = 1'b0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        ack_cnt_d = ack_cnt_q + 1'b1;
      end
    end
    unique case (state_q)
      S_IDLE: begin
        if (start_i || enable_i) begin
          state_d    = S_TICK;
          err_d      = 1'b0;
          poll_cnt_d = '0;
        end
      end
      S_TICK: begin
        if (ack_ok) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(POLL_GAP - 1))
          state_d = S_POLL;
        else
          gap_cnt_d = gap_cnt_q + 1'b1;
      end
      S_POLL: begin
        if (ack_ok) begin
          if (wb_dat_i[1]) begin
            state_d = S_RD_SQ;
          end else if (poll_cnt_q >= PW'(POLL_LIMIT)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
            gap_cnt_d  = '0;
            state_d    = S_GAP;
          end
        end
      end
      S_RD_SQ: begin
        if (ack_ok) begin
          sq_d    = wb_dat_i[23:0];
          state_d = S_RD_GT;
        end
      end
      S_RD_GT: begin
        if (ack_ok) begin
          gt_d    = wb_dat_i[20:0];
          state_d = S_RD_LT;
        end
      end
      S_RD_LT: begin
        if (ack_ok) begin
          lt_d    = wb_dat_i[20:0];
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        scale_d  = s_sat;
        offset_d = o_sat;
        state_d  = S_WR_SCALE;
      end
      S_WR_SCALE: if (ack_ok) state_d = S_WR_OFF;
      S_WR_OFF:   if (ack_ok) state_d = S_APPLY;
      S_APPLY:    if (ack_ok) state_d = S_FIN;
      S_FIN: begin
        if (enable_i) begin
          state_d    = S_TICK;
          poll_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wb_cyc_o = stb_q;
    wb_stb_o = stb_q;
    wb_sel_o = 4'hF;
    wb_we_o  = 1'b0;
    wb_dat_o = 32'h0;
    wb_adr_o = BASE_ADDR;
    unique case (state_q)
      S_TICK: begin
        wb_we_o  = 1'b1;
        wb_dat_o = 32'h1;
      end
      S_RD_SQ: wb_adr_o = BASE_ADDR + 22'h04;
      S_RD_GT: wb_adr_o = BASE_ADDR + 22'h08;
      S_RD_LT: wb_adr_o = BASE_ADDR + 22'h0C;
      S_WR_SCALE: begin
        wb_we_o  = 1'b1;
        wb_adr_o = BASE_ADDR + 22'h10;
        wb_dat_o = {15'h0, scale_q};
      end
      S_WR_OFF: begin
        wb_we_o  = 1'b1;
        wb_adr_o = BASE_ADDR + 22'h14;
        wb_dat_o = {24'h0, offset_q};
      end
      S_APPLY: begin
        wb_we_o  = 1'b1;
        wb_dat_o = 32'h700;
      end
      default: ;
    endcase
    busy_o   = (state_q != S_IDLE) && (state_q != S_FIN);
    done_o   = (state_q == S_FIN);
    err_o    = err_q;
    scale_o  = scale_q;
    offset_o = offset_q;
    sq_o     = sq_q;
    gt_o     = gt_q;
    lt_o     = lt_q;
  end

endmodule

// File: tb/tb_agc_loop_master.sv
// Bench for agc_loop_master: Wishbone target model plus a bus-transaction
// scoreboard fed by directed iterations with hand-computed results.
module tb_agc_loop_master;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start_i, enable_i;
  logic [23:0] target_i;
  logic        busy_o, done_o, err_o;
  logic [16:0] scale_o;
  logic [7:0]  offset_o;
  logic [23:0] sq_o;
  logic [20:0] gt_o, lt_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [21:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;

  agc_loop_master #(
    .POLL_GAP(4), .POLL_LIMIT(4), .ACK_TIMEOUT(64)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .start_i(start_i), .enable_i(enable_i), .target_i(target_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .scale_o(scale_o), .offset_o(offset_o),
    .sq_o(sq_o), .gt_o(gt_o), .lt_o(lt_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  // Target model
  logic [31:0] sq_val, gt_val, lt_val;
  int          done_after, ack_wait;
  logic        withhold;
  int          polls_seen = 0;
  int          wcnt = 0;
  int          stb_total = 0;

  always_comb begin
    wb_dat_i = 32'h0;
    case (wb_adr_o)
      22'h00: wb_dat_i = {30'h0, (polls_seen >= done_after), 1'b0};
      22'h04: wb_dat_i = sq_val;
      22'h08: wb_dat_i = gt_val;
      22'h0C: wb_dat_i = lt_val;
      default: wb_dat_i = 32'h0;
    endcase
  end

  always @(posedge aclk) begin
    if (wb_stb_o) stb_total <= stb_total + 1;
    if (!aresetn || wb_ack_i) begin
      wb_ack_i <= 1'b0;
      wcnt     <= 0;
    end else if (wb_cyc_o && wb_stb_o && !withhold) begin
      if (wcnt >= ack_wait) begin
        wb_ack_i <= 1'b1;
        wcnt     <= 0;
        if (wb_adr_o == 22'h0 && !wb_we_o)
          polls_seen <= polls_seen + 1;
        if (wb_adr_o == 22'h0 && wb_we_o && wb_dat_o == 32'h1)
          polls_seen <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // Scoreboard
  typedef struct {
    logic        we;
    logic [21:0] adr;
    logic [31:0] dat;
  } txn_t;
  txn_t exp_q[$];
  txn_t mt;
  int   done_cnt = 0;

  task automatic push(logic we, logic [21:0] adr, logic [31:0] dat);
    txn_t t;
    t.we = we; t.adr = adr; t.dat = dat;
    exp_q.push_back(t);
  endtask

  task automatic exp_iter(int polls, logic [31:0] sc, logic [31:0] of);
    push(1'b1, 22'h00, 32'h1);
    for (int i = 0; i < polls; i++) push(1'b0, 22'h00, 32'h0);
    push(1'b0, 22'h04, 32'h0);
    push(1'b0, 22'h08, 32'h0);
    push(1'b0, 22'h0C, 32'h0);
    push(1'b1, 22'h10, sc);
    push(1'b1, 22'h14, of);
    push(1'b1, 22'h00, 32'h700);
  endtask

  always @(negedge aclk) begin
    if (done_o) done_cnt <= done_cnt + 1;
    if (aresetn && wb_cyc_o && wb_stb_o && wb_ack_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bus_unexpected adr=%h we=%b dat=%h",
                 wb_adr_o, wb_we_o, wb_dat_o);
      end else begin
        mt = exp_q.pop_front();
        check("bus_adr", {10'h0, wb_adr_o}, {10'h0, mt.adr});
        check("bus_we", {31'h0, wb_we_o}, {31'h0, mt.we});
        check("bus_sel", {28'h0, wb_sel_o}, 32'hF);
        if (mt.we) check("bus_dat", wb_dat_o, mt.dat);
      end
    end
  end

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge aclk);
    start_i = 1'b1;
    @(negedge aclk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(int n, int max, string name);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge aclk);
      #1;
      if (done_cnt >= n) break;
    end
    if (i == max) timeout_fail(name);
  endtask

  task automatic wait_err(int max, string name);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge aclk);
      #1;
      if (err_o && !busy_o) break;
    end
    if (i == max) timeout_fail(name);
  endtask

  task automatic set_acc(logic [31:0] sq, logic [31:0] gt, logic [31:0] lt);
    sq_val = sq; gt_val = gt; lt_val = lt;
  endtask

  int base, st0, k;

  initial begin
    aresetn = 1'b0; start_i = 1'b0; enable_i = 1'b0; target_i = '0;
    set_acc(32'h0, 32'h0, 32'h0);
    done_after = 1; ack_wait = 0; withhold = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    check("rst_scale", {15'h0, scale_o}, 32'h1000);
    check("rst_offset", {24'h0, offset_o}, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_done", {31'h0, done_o}, 32'h0);
    check("rst_err", {31'h0, err_o}, 32'h0);
    check("rst_cyc", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
    check("rst_sq", {8'h0, sq_o}, 32'h0);
    aresetn = 1'b1;

    // 1: nominal iteration, upper read bits are garbage
    set_acc(32'hAB010000, 32'hFFE00005, 32'h00000005);
    target_i = 24'h020000;
    base = done_cnt;
    exp_iter(1, 32'h1100, 32'h0);
    pulse_start();
    repeat (8) @(negedge aclk);
    start_i = 1'b1;
    @(negedge aclk);
    start_i = 1'b0;
    wait_done(base + 1, 300, "t1_done");
    repeat (20) @(negedge aclk);
    #1;
    check("t1_scale", {15'h0, scale_o}, 32'h1100);
    check("t1_offset", {24'h0, offset_o}, 32'h0);
    check("t1_sq", {8'h0, sq_o}, 32'h010000);
    check("t1_gt", {11'h0, gt_o}, 32'h5);
    check("t1_lt", {11'h0, lt_o}, 32'h5);
    check("t1_done_cnt", done_cnt - base, 1);
    check("t1_busy", {31'h0, busy_o}, 32'h0);
    check("t1_q_empty", exp_q.size(), 0);

    // 2: setup iteration then both saturations
    do_reset();
    target_i = 24'h0;
    set_acc(32'h000FF000, 32'h0, 32'h19000);
    base = done_cnt;
    exp_iter(1, 32'h10, 32'h64);
    pulse_start();
    wait_done(base + 1, 300, "t2a_done");
    #1;
    check("t2a_scale", {15'h0, scale_o}, 32'h10);
    check("t2a_offset", {24'h0, offset_o}, 32'h64);
    set_acc(32'h00FFFFFF, 32'h0, 32'h40000);
    exp_iter(1, 32'h0, 32'h7F);
    repeat (2) @(negedge aclk);
    pulse_start();
    wait_done(base + 2, 300, "t2b_done");
    #1;
    check("t2_scale_sat", {15'h0, scale_o}, 32'h0);
    check("t2_offset_sat", {24'h0, offset_o}, 32'h7F);
    check("t2_q_empty", exp_q.size(), 0);

    // 3: done never set, poll limit reached
    do_reset();
    done_after = 1000;
    base = done_cnt;
    push(1'b1, 22'h00, 32'h1);
    for (int i = 0; i < 5; i++) push(1'b0, 22'h00, 32'h0);
    pulse_start();
    wait_err(500, "t3_err");
    repeat (10) @(negedge aclk);
    #1;
    check("t3_err", {31'h0, err_o}, 32'h1);
    check("t3_busy", {31'h0, busy_o}, 32'h0);
    check("t3_polls", polls_seen, 5);
    check("t3_scale", {15'h0, scale_o}, 32'h1000);
    check("t3_offset", {24'h0, offset_o}, 32'h0);
    check("t3_no_done", done_cnt - base, 0);
    check("t3_q_empty", exp_q.size(), 0);

    // 4: ack withheld on tick, then recovery
    do_reset();
    withhold = 1'b1;
    done_after = 1;
    st0 = stb_total;
    pulse_start();
    wait_err(300, "t4_err");
    #1;
    check("t4_stb_cycles", stb_total - st0, 64);
    check("t4_err", {31'h0, err_o}, 32'h1);
    check("t4_cyc", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
    withhold = 1'b0;
    set_acc(32'h00020000, 32'h400, 32'h0);
    target_i = 24'h010000;
    base = done_cnt;
    exp_iter(1, 32'hF00, 32'hFF);
    @(negedge aclk);
    start_i = 1'b1;
    @(negedge aclk);
    start_i = 1'b0;
    #1;
    check("t4_err_clr", {31'h0, err_o}, 32'h0);
    wait_done(base + 1, 300, "t4_done");
    #1;
    check("t4_scale", {15'h0, scale_o}, 32'hF00);
    check("t4_offset", {24'h0, offset_o}, 32'hFF);
    check("t4_q_empty", exp_q.size(), 0);

    // 5: back-to-back via enable, dropped during third gt read
    do_reset();
    set_acc(32'h1000, 32'h5, 32'h5);
    target_i = 24'h001100;
    base = done_cnt;
    exp_iter(1, 32'h1001, 32'h0);
    exp_iter(1, 32'h1002, 32'h0);
    exp_iter(1, 32'h1003, 32'h0);
    @(negedge aclk);
    enable_i = 1'b1;
    for (k = 0; k < 600; k++) begin
      @(negedge aclk);
      #1;
      if (done_cnt == base + 2 && wb_stb_o && wb_adr_o == 22'h08) break;
    end
    if (k == 600) timeout_fail("t5_rd_gt");
    enable_i = 1'b0;
    wait_done(base + 3, 300, "t5_done");
    repeat (30) @(negedge aclk);
    #1;
    check("t5_done_cnt", done_cnt - base, 3);
    check("t5_busy", {31'h0, busy_o}, 32'h0);
    check("t5_cyc", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
    check("t5_scale", {15'h0, scale_o}, 32'h1003);
    check("t5_q_empty", exp_q.size(), 0);

    // 6: reset during the offset write
    do_reset();
    ack_wait = 3;
    done_after = 1;
    set_acc(32'h010000, 32'h5, 32'h5);
    target_i = 24'h020000;
    base = done_cnt;
    push(1'b1, 22'h00, 32'h1);
    push(1'b0, 22'h00, 32'h0);
    push(1'b0, 22'h04, 32'h0);
    push(1'b0, 22'h08, 32'h0);
    push(1'b0, 22'h0C, 32'h0);
    push(1'b1, 22'h10, 32'h1100);
    pulse_start();
    for (k = 0; k < 600; k++) begin
      @(negedge aclk);
      #1;
      if (wb_stb_o && wb_adr_o == 22'h14) break;
    end
    if (k == 600) timeout_fail("t6_wr_off");
    check("t6_scale_pre", {15'h0, scale_o}, 32'h1100);
    aresetn = 1'b0;
    #1;
    check("t6_cyc_async", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (20) @(negedge aclk);
    #1;
    check("t6_scale", {15'h0, scale_o}, 32'h1000);
    check("t6_busy", {31'h0, busy_o}, 32'h0);
    check("t6_cyc", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
    check("t6_no_done", done_cnt - base, 0);
    check("t6_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
